// File: rtl/fg_wave_sequencer.sv
// Function-generator sequencer: paces up to NUM_WAVES waveform generators
// with a shared tick enable and restart pulse, and routes the selected
// generator's sample onto a registered 8-bit DAC output. In auto mode it
// rotates through the generators, dwelling a programmable number of ticks
// on each.
module fg_wave_sequencer #(
  parameter int         NUM_WAVES = 4,
  parameter int         SEL_W     = 2,
  parameter logic [7:0] MID_CODE  = 8'h80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   auto_mode_i,
  input  logic [SEL_W-1:0]       wave_sel_i,
  input  logic [7:0]             freq_div_i,
  input  logic [7:0]             dwell_i,
  input  logic [8*NUM_WAVES-1:0] wave_bus_i,
  output logic                   gen_en_o,
  output logic                   gen_rst_o,
  output logic [SEL_W-1:0]       active_sel_o,
  output logic [7:0]             dac_out_o,
  output logic                   dac_valid_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_SWITCH
  } state_e;

  state_e           state_q;
  logic [7:0]       div_q;
  logic [7:0]       dwell_q;
  logic             auto_q;
  logic [7:0]       presc_q;
  logic [7:0]       tick_q;
  logic [SEL_W-1:0] sel_q;
  logic [7:0]       dac_q;
  logic             dac_valid_q;

  logic             tick_en;
  logic             switch_now;
  logic [7:0]       sample;
  logic [SEL_W-1:0] sel_arm_d;
  logic [SEL_W-1:0] sel_next_d;

  // Tick fires on the last prescaler count of each period while running.
  assign tick_en    = (state_q == S_RUN) && (presc_q == div_q);
  // Dwell of zero disables rotation entirely.
  assign switch_now = tick_en && auto_q && (dwell_q != 8'd0) &&
                      (tick_q == dwell_q - 8'd1);

  // Out-of-range start selections fall back to generator 0.
  assign sel_arm_d  = (int'(wave_sel_i) >= NUM_WAVES) ? '0 : wave_sel_i;
  // Rotation wraps at NUM_WAVES, not at the width of the select field.
  assign sel_next_d = (int'(sel_q) == NUM_WAVES - 1) ? '0 : sel_q + SEL_W'(1);

  // Select the active generator's sample from the packed bus.
  always_comb begin
    // NOTE: assign a default before any conditional write so no latch is inferred.
    sample = MID_CODE;
    for (int i = 0; i < NUM_WAVES; i++) begin
      if (int'(sel_q) == i) sample = wave_bus_i[8*i +: 8];
    end
  end

  // Sequencer state, prescaler/dwell counters, config latch and DAC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      dwell_q     <= '0;
      auto_q      <= 1'b0;
      presc_q     <= '0;
      tick_q      <= '0;
      sel_q       <= '0;
      dac_q       <= MID_CODE;
      dac_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      dac_valid_q <= 1'b0;
      if (state_q != S_IDLE && stop_i) begin
        // Abort wins over any tick or switch on this edge; selection is kept.
        state_q <= S_IDLE;
        presc_q <= '0;
        tick_q  <= '0;
        dac_q   <= MID_CODE;
      end else begin
        case (state_q)
          S_IDLE: begin
            dac_q   <= MID_CODE;
            presc_q <= '0;
            tick_q  <= '0;
            if (start_i && !stop_i) state_q <= S_ARM;
          end
          S_ARM: begin
            div_q   <= freq_div_i;
            dwell_q <= dwell_i;
            auto_q  <= auto_mode_i;
            sel_q   <= sel_arm_d;
            presc_q <= '0;
            tick_q  <= '0;
            state_q <= S_RUN;
          end
          S_RUN: begin
            if (tick_en) begin
              dac_q       <= sample;
              dac_valid_q <= 1'b1;
              presc_q     <= '0;
              if (tick_q != 8'hFF) tick_q <= tick_q + 8'd1;
              if (switch_now) state_q <= S_SWITCH;
            end else begin
              presc_q <= presc_q + 8'd1;
            end
          end
          S_SWITCH: begin
            sel_q   <= sel_next_d;
            presc_q <= '0;
            tick_q  <= '0;
            state_q <= S_RUN;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign gen_en_o     = tick_en;
  assign gen_rst_o    = (state_q == S_ARM) || (state_q == S_SWITCH);
  assign busy_o       = (state_q != S_IDLE);
  assign active_sel_o = sel_q;
  assign dac_out_o    = dac_q;
  assign dac_valid_o  = dac_valid_q;

endmodule

// File: tb/tb_fg_wave_sequencer.sv
// Directed bench for fg_wave_sequencer: a 4-wave instance and a 3-wave
// instance sharing control inputs, with hand-computed expectations.
module tb_fg_wave_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        auto_mode;
  logic [1:0]  wave_sel;
  logic [7:0]  freq_div;
  logic [7:0]  dwell;
  logic [31:0] wave_bus;
  logic [23:0] wave_bus3;

  logic        gen_en,  gen_rst,  dac_valid,  busy;
  logic [1:0]  active_sel;
  logic [7:0]  dac_out;
  logic        gen_en3, gen_rst3, dac_valid3, busy3;
  logic [1:0]  active_sel3;
  logic [7:0]  dac_out3;

  int tests = 0;
  int fails = 0;

  fg_wave_sequencer u_dut (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
    .auto_mode_i(auto_mode), .wave_sel_i(wave_sel), .freq_div_i(freq_div),
    .dwell_i(dwell), .wave_bus_i(wave_bus),
    .gen_en_o(gen_en), .gen_rst_o(gen_rst), .active_sel_o(active_sel),
    .dac_out_o(dac_out), .dac_valid_o(dac_valid), .busy_o(busy)
  );

  fg_wave_sequencer #(.NUM_WAVES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
    .auto_mode_i(auto_mode), .wave_sel_i(wave_sel), .freq_div_i(freq_div),
    .dwell_i(dwell), .wave_bus_i(wave_bus3),
    .gen_en_o(gen_en3), .gen_rst_o(gen_rst3), .active_sel_o(active_sel3),
    .dac_out_o(dac_out3), .dac_valid_o(dac_valid3), .busy_o(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and observe just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dac_out"},    dac_out,    32'h80);
    check({tag, " busy"},       busy,       32'h0);
    check({tag, " gen_en"},     gen_en,     32'h0);
    check({tag, " gen_rst"},    gen_rst,    32'h0);
    check({tag, " active_sel"}, active_sel, 32'h0);
    check({tag, " dac_valid"},  dac_valid,  32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; auto_mode = 1'b0;
    wave_sel = 2'd0; freq_div = 8'd0; dwell = 8'd0;
    wave_bus  = 32'h44332211;
    wave_bus3 = 24'hCCBBAA;

    // Power-on reset
    step(); step();
    check_reset_outputs("por");
    rst = 1'b0;
    step();
    check("idle busy", busy, 32'h0);
    check("idle dac", dac_out, 32'h80);

    // Manual mode, wave 2, tick every 4 RUN cycles
    wave_sel = 2'd2; freq_div = 8'd3; dwell = 8'd0; auto_mode = 1'b0; start = 1'b1;
    step();
    check("arm gen_rst", gen_rst, 32'h1);
    check("arm busy", busy, 32'h1);
    check("arm gen_en", gen_en, 32'h0);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("man c%0d gen_en", c), gen_en, (c % 4 == 0) ? 32'h1 : 32'h0);
      check($sformatf("man c%0d gen_rst", c), gen_rst, 32'h0);
      check($sformatf("man c%0d busy", c), busy, 32'h1);
      check($sformatf("man c%0d sel", c), active_sel, 32'h2);
      check($sformatf("man c%0d valid", c), dac_valid, (c == 5 || c == 9) ? 32'h1 : 32'h0);
      check($sformatf("man c%0d dac", c), dac_out, (c >= 5) ? 32'h33 : 32'h80);
      // Config changes and a start re-pulse while busy must be ignored.
      if (c == 2) begin wave_sel = 2'd0; freq_div = 8'd0; end
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
    end
    step();
    check("man c13 valid", dac_valid, 32'h1);
    check("man c13 dac", dac_out, 32'h33);
    stop = 1'b1;
    step();
    check("stop busy", busy, 32'h0);
    check("stop dac", dac_out, 32'h80);
    check("stop sel held", active_sel, 32'h2);
    check("stop gen_en", gen_en, 32'h0);
    stop = 1'b0;

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    step();
    check("ss busy", busy, 32'h0);
    check("ss gen_rst", gen_rst, 32'h0);
    step();
    check("ss busy2", busy, 32'h0);
    start = 1'b0; stop = 1'b0;

    // Auto mode, dwell 3, tick every cycle, start at wave 3
    wave_sel = 2'd3; freq_div = 8'd0; dwell = 8'd3; auto_mode = 1'b1; start = 1'b1;
    step();
    check("auto arm gen_rst", gen_rst, 32'h1);
    start = 1'b0;
    step();
    check("auto r1 gen_en", gen_en, 32'h1);
    check("auto r1 sel", active_sel, 32'h3);
    check("auto r1 gen_rst", gen_rst, 32'h0);
    step();
    check("auto r2 gen_en", gen_en, 32'h1);
    check("auto r2 dac", dac_out, 32'h44);
    check("auto r2 valid", dac_valid, 32'h1);
    step();
    check("auto r3 gen_en", gen_en, 32'h1);
    step();
    check("auto sw1 gen_rst", gen_rst, 32'h1);
    check("auto sw1 gen_en", gen_en, 32'h0);
    check("auto sw1 busy", busy, 32'h1);
    check("auto sw1 dac", dac_out, 32'h44);
    step();
    check("auto wrap sel", active_sel, 32'h0);
    check("auto s0 gen_en", gen_en, 32'h1);
    check("auto s0 gen_rst", gen_rst, 32'h0);
    check("auto s0 valid", dac_valid, 32'h0);
    check("auto s0 dac held", dac_out, 32'h44);
    step();
    check("auto s0 dac", dac_out, 32'h11);
    step();
    check("auto s0 r3 gen_en", gen_en, 32'h1);
    step();
    check("auto sw2 gen_rst", gen_rst, 32'h1);
    step();
    check("auto sel1", active_sel, 32'h1);
    check("auto s1 gen_en", gen_en, 32'h1);

    // stop coincident with the switch condition
    step();
    check("auto s1 dac", dac_out, 32'h22);
    step();
    check("swstop pre gen_en", gen_en, 32'h1);
    stop = 1'b1;
    step();
    check("swstop busy", busy, 32'h0);
    check("swstop gen_rst", gen_rst, 32'h0);
    check("swstop dac", dac_out, 32'h80);
    check("swstop sel", active_sel, 32'h1);
    check("swstop gen_en", gen_en, 32'h0);
    step();
    check("swstop sel later", active_sel, 32'h1);
    check("swstop busy later", busy, 32'h0);
    stop = 1'b0;

    // Clamp on 3-wave instance; dwell 0 never switches
    wave_sel = 2'd3; freq_div = 8'd0; dwell = 8'd0; auto_mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("clamp sel3", active_sel3, 32'h0);
    check("noclamp sel", active_sel, 32'h3);
    for (int t = 0; t < 600; t++) begin
      step();
      check($sformatf("dw0 t%0d", t), {gen_rst, gen_en, active_sel}, {1'b0, 1'b1, 2'd3});
      check($sformatf("dw0 n3 t%0d", t), {gen_rst3, active_sel3}, {1'b0, 2'd0});
    end
    check("dw0 dac", dac_out, 32'h44);
    check("dw0 dac3", dac_out3, 32'hAA);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Wrap at NUM_WAVES: 3-wave 2->0 while 4-wave 2->3->0
    wave_sel = 2'd2; freq_div = 8'd1; dwell = 8'd1; auto_mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("wr r1 gen_en", gen_en, 32'h0);
    step();
    check("wr r2 gen_en", gen_en, 32'h1);
    step();
    check("wr sw gen_rst", gen_rst, 32'h1);
    check("wr sw gen_rst3", gen_rst3, 32'h1);
    step();
    check("wr sel3 wrap", active_sel3, 32'h0);
    check("wr sel", active_sel, 32'h3);
    step(); step(); step();
    check("wr sel3 next", active_sel3, 32'h1);
    check("wr sel wrap", active_sel, 32'h0);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Asynchronous reset in the middle of a run
    wave_sel = 2'd1; freq_div = 8'd2; dwell = 8'd0; auto_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    check("mid busy", busy, 32'h1);
    check("mid dac", dac_out, 32'h22);
    check("mid valid", dac_valid, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async rst");
    step();
    check_reset_outputs("rst held");
    rst = 1'b0;
    step();
    check("post rst busy", busy, 32'h0);
    check("post rst dac", dac_out, 32'h80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
